// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and buffers {pc, instr} pairs for IF/ID. Optional counters under FETCH_PERF_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; issue one when buffer space is reserved
// FETCH | request outstanding; its response is pushed into the buffer
// DRAIN | request outstanding after a redirect; its response is dropped
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    input  logic            halt,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_discarded,
`endif
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] WORD    = XLEN'(4);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic            req_next;
    logic [XLEN-1:0] addr_next;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_after;

    logic            transfer, push, pop, space_next, resp_drop;
    logic [XLEN-1:0] target_pc;
    logic            unused_rpc_bits;

    assign target_pc       = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign transfer  = imem_req && imem_ack;
    assign push      = (state == FETCH) && transfer && !redirect;
    assign pop       = if_valid && !stall && !halt && !redirect;
    assign resp_drop = transfer && ((state == DRAIN) || redirect);

    // Requests are only issued when the eventual push is guaranteed a slot.
    assign count_after = redirect ? '0 : (count + CW'(push) - CW'(pop));
    assign space_next  = count_after < DEPTH_C;

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
    assign if_instr = if_valid ? instr_mem[rd_ptr] : NOP;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_next      = imem_req;
        addr_next     = imem_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                end else if (!halt && space_next) begin
                    state_next = FETCH;
                    req_next   = 1'b1;
                    addr_next  = fetch_pc;
                end
            end
            FETCH: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                    if (transfer) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (transfer) begin
                    fetch_pc_next = imem_addr + WORD;
                    if (!halt && space_next) begin
                        addr_next = imem_addr + WORD;
                    end else begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                end
                if (transfer) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_after;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked by if_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched   <= '0;
            perf_discarded <= '0;
        end else begin
            perf_fetched   <= perf_fetched + 32'(push);
            perf_discarded <= perf_discarded + (redirect ? 32'(count) : 32'd0)
                              + 32'(resp_drop);
        end
    end
`endif

endmodule
